// File: rtl/nv_ram_fifo_ctrl_60x84.sv
// ---------------------------------------------------------------------------
// nv_ram_fifo_ctrl_60x84
//
// Runs a 60x84 two-port synchronous RAM as a FIFO. The RAM registers its
// read address (ra -> ra_d on re) and has an output register loaded on ore,
// fed either from mem[ra_d] or, with byp_sel, from dbyp. This block turns a
// valid/ready push port and a valid/ready pop port into those RAM strobes,
// tracks the two-stage read pipeline and keeps the entry held in ra_d safe
// from being overwritten until the output register has captured it.
//
// Optional build macro:
//   NV_RAM_FIFO_BYPASS_EN - when defined, a push into an empty pipeline is
//                           loaded straight into the RAM output register
//                           (1-cycle latency). When undefined every entry
//                           goes through the RAM (3-cycle latency).
//
// Ports:
//   nvdla_core_clk   core clock, all state on the rising edge
//   nvdla_core_rstn  asynchronous active-low reset
//   push_valid/push_ready/push_data   producer interface
//   pop_valid/pop_ready/pop_data      consumer interface (pop_data = ram_dout)
//   ram_ra/ram_re                     RAM read address and its register enable
//   ram_ore                           RAM output-register enable
//   ram_wa/ram_we/ram_di              RAM write port
//   ram_byp_sel/ram_dbyp              RAM bypass mux control and data
//   ram_dout                          RAM output register
//   fifo_count                        entries held (RAM + output register)
//   idle                              empty and no read in flight
// ---------------------------------------------------------------------------
module nv_ram_fifo_ctrl_60x84 #(
  parameter int DEPTH = 60,
  parameter int WIDTH = 84,
  parameter int AW    = 6,
  parameter int CW    = 7
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [CW-1:0]    fifo_count,
  output logic             idle
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] ram_used;  // written, not yet captured by ore
  logic [CW-1:0] rd_avail;  // written, not yet issued via re
  logic          s1_vld;    // an address sits in the RAM's ra_d
  logic          out_vld;   // RAM output register holds unpopped data

  logic push_fire;
  logic pop_fire;
  logic out_free;
  logic adv;
  logic byp;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // ram_used still counts the entry parked in ra_d, so the write pointer can
  // never land on it while a read of it is pending.
  assign push_ready = (ram_used < CW'(DEPTH));
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = out_vld & pop_ready;
  assign out_free   = ~out_vld | pop_ready;
  assign adv        = s1_vld & out_free;

`ifdef NV_RAM_FIFO_BYPASS_EN
  // Only bypass when nothing older is queued or in the read pipeline,
  // otherwise ordering would break.
  assign byp = push_fire & (rd_avail == '0) & ~s1_vld & out_free;
`else
  assign byp = 1'b0;
`endif

  assign ram_we      = push_fire & ~byp;
  assign ram_wa      = wr_ptr;
  assign ram_di      = push_data;
  assign ram_dbyp    = push_data;
  // A read may be issued when ra_d is empty or is being drained this cycle;
  // a word written this cycle only shows up in rd_avail next cycle.
  assign ram_re      = (rd_avail != '0) & (~s1_vld | adv);
  assign ram_ra      = rd_ptr;
  // adv and byp are exclusive since byp requires !s1_vld.
  assign ram_ore     = adv | byp;
  assign ram_byp_sel = byp;

  assign pop_valid   = out_vld;
  assign pop_data    = ram_dout;
  assign fifo_count  = ram_used + CW'(out_vld);
  assign idle        = (fifo_count == '0) & ~s1_vld;

  // NOTE: every control register sits on the asynchronous reset so an abort
  // discards the FIFO immediately; the RAM array itself is never cleared
  // because stale words are unreachable once the counters read zero.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_used <= '0;
      rd_avail <= '0;
      s1_vld   <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees the
      // pre-edge values of its neighbours, matching the combinational strobes.
      if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
      ram_used <= ram_used + CW'(ram_we) - CW'(adv);
      rd_avail <= rd_avail + CW'(ram_we) - CW'(ram_re);
      s1_vld   <= ram_re | (s1_vld & ~adv);
      out_vld  <= ram_ore | (out_vld & ~pop_fire);
    end
  end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_60x84.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_fifo_ctrl_60x84
//
// Bench for nv_ram_fifo_ctrl_60x84 with a behavioural model of the 60x84
// RAM (registered read address, output register, bypass mux). Accepted push
// words go into a scoreboard queue; a monitor pops and compares on every
// pop handshake. Directed sequences cover reset, latency, full/refill,
// steady-state streaming, random handshakes and a mid-run reset.
// ---------------------------------------------------------------------------
module tb_nv_ram_fifo_ctrl_60x84;

  localparam int DEPTH = 60;
  localparam int WIDTH = 84;
  localparam int AW    = 6;
  localparam int CW    = 7;

`ifdef NV_RAM_FIFO_BYPASS_EN
  localparam int EXP_LAT    = 1;
  localparam int FREED_ADDR = 0;
`else
  localparam int EXP_LAT    = 3;
  localparam int FREED_ADDR = 1;
`endif

  typedef logic [WIDTH-1:0] word_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic [AW-1:0]    ram_ra;
  logic             ram_re;
  logic             ram_ore;
  logic [AW-1:0]    ram_wa;
  logic             ram_we;
  logic [WIDTH-1:0] ram_di;
  logic             ram_byp_sel;
  logic [WIDTH-1:0] ram_dbyp;
  logic [WIDTH-1:0] ram_dout;
  logic [CW-1:0]    fifo_count;
  logic             idle;

  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_60x84 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_data       (push_data),
    .pop_valid       (pop_valid),
    .pop_ready       (pop_ready),
    .pop_data        (pop_data),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_byp_sel     (ram_byp_sel),
    .ram_dbyp        (ram_dbyp),
    .ram_dout        (ram_dout),
    .fifo_count      (fifo_count),
    .idle            (idle)
  );

  // RAM model
  word_t         mem [DEPTH];
  logic [AW-1:0] ra_d;
  word_t         dout_q;

  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_d        <= ram_ra;
    if (ram_ore) dout_q      <= ram_byp_sel ? ram_dbyp : mem[ra_d];
  end
  assign ram_dout = dout_q;

  // Scoreboard and counters
  word_t exp_q[$];
  int    total    = 0;
  int    bad      = 0;
  int    push_acc = 0;
  int    pop_cnt  = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change at posedge+1, so the negedge sees the handshake
  // that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count_max", word_t'(fifo_count <= CW'(61)), word_t'(1));
      if (push_valid && push_ready) begin
        exp_q.push_back(push_data);
        push_acc++;
      end
      if (pop_valid && pop_ready) begin
        check("sb_nonempty", word_t'(exp_q.size() != 0), word_t'(1));
        if (exp_q.size() != 0) check("pop_data", pop_data, exp_q.pop_front());
        pop_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int cyc;
    pop_ready = 1'b1;
    cyc = 0;
    while (fifo_count != '0 && cyc < 500) begin
      tick();
      cyc++;
    end
    check({name, "_drained"}, word_t'(fifo_count), word_t'(0));
    check({name, "_sb_empty"}, word_t'(exp_q.size()), word_t'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int    lat, cyc, acc0, p0, sent;
    logic  acc;

    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
    #1 rst_n = 1'b0;
    #22;
    check("rst_push_ready", word_t'(push_ready), word_t'(1));
    check("rst_pop_valid",  word_t'(pop_valid),  word_t'(0));
    check("rst_we",         word_t'(ram_we),     word_t'(0));
    check("rst_re",         word_t'(ram_re),     word_t'(0));
    check("rst_ore",        word_t'(ram_ore),    word_t'(0));
    check("rst_byp_sel",    word_t'(ram_byp_sel), word_t'(0));
    check("rst_count",      word_t'(fifo_count), word_t'(0));
    check("rst_idle",       word_t'(idle),       word_t'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single word latency
    p0         = pop_cnt;
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = 84'hA5;
    tick();
    push_valid = 1'b0;
    lat = 1;
    while (!pop_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("single_latency", word_t'(lat), word_t'(EXP_LAT));
    tick();
    tick();
    check("single_pops",  word_t'(pop_cnt - p0), word_t'(1));
    check("single_count", word_t'(fifo_count), word_t'(0));
    check("single_idle",  word_t'(idle), word_t'(1));

    // Fill from a fresh reset so the pointer positions are known
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pop_ready = 1'b0;
    acc0 = push_acc;
    for (int i = 0; i <= 70; i++) begin
      push_valid = 1'b1;
      push_data  = word_t'(i);
      tick();
    end
    push_valid = 1'b0;
    #1;
    check("fill_accepted",   word_t'(push_acc - acc0), word_t'(61));
    check("fill_count",      word_t'(fifo_count), word_t'(61));
    check("fill_push_ready", word_t'(push_ready), word_t'(0));

    // Pop one: push_ready rises after the freeing advance, refill goes to
    // the freed address
    pop_ready = 1'b1;
    #1;
    check("full_ready_before_adv", word_t'(push_ready), word_t'(0));
    tick();
    pop_ready = 1'b0;
    check("ready_after_adv", word_t'(push_ready), word_t'(1));
    push_valid = 1'b1;
    push_data  = word_t'(100);
    #1;
    check("freed_we", word_t'(ram_we), word_t'(1));
    check("freed_wa", word_t'(ram_wa), word_t'(FREED_ADDR));
    tick();
    push_valid = 1'b0;
    #1;
    check("refull_count", word_t'(fifo_count), word_t'(61));
    check("refull_ready", word_t'(push_ready), word_t'(0));

    // Drain without gaps
    p0 = pop_cnt;
    pop_ready = 1'b1;
    cyc = 0;
    while (fifo_count != '0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("drain_cycles", word_t'(cyc), word_t'(61));
    check("drain_pops",   word_t'(pop_cnt - p0), word_t'(61));
    check("drain_sb_empty", word_t'(exp_q.size()), word_t'(0));

    // Steady count 30 with push and pop every cycle
    pop_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      push_valid = 1'b1;
      push_data  = word_t'(1000 + k);
      tick();
    end
    push_valid = 1'b0;
    repeat (4) tick();
    check("steady_fill_count", word_t'(fifo_count), word_t'(30));
    for (int k = 0; k < 50; k++) begin
      push_valid = 1'b1;
      pop_ready  = 1'b1;
      push_data  = word_t'(2000 + k);
      @(negedge clk);
      check("steady_we",    word_t'(ram_we), word_t'(1));
      check("steady_re",    word_t'(ram_re), word_t'(1));
      check("steady_count", word_t'(fifo_count), word_t'(30));
      tick();
    end
    push_valid = 1'b0;
    drain("steady");

    // Random handshakes, 200 words
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 5000) begin
      push_valid = 1'($urandom_range(0, 1));
      pop_ready  = 1'($urandom_range(0, 1));
      push_data  = word_t'(5000 + sent);
      @(negedge clk);
      acc = push_valid & push_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    push_valid = 1'b0;
    check("stream_sent", word_t'(sent), word_t'(200));
    drain("stream");

    // Reset in the middle of traffic
    pop_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      push_valid = 1'b1;
      push_data  = word_t'(7000 + k);
      tick();
    end
    push_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_pop_valid",  word_t'(pop_valid),  word_t'(0));
    check("midrst_count",      word_t'(fifo_count), word_t'(0));
    check("midrst_push_ready", word_t'(push_ready), word_t'(1));
    check("midrst_idle",       word_t'(idle),       word_t'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    p0         = pop_cnt;
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = 84'h1;
    tick();
    push_valid = 1'b0;
    drain("post_reset");
    check("post_reset_pops", word_t'(pop_cnt - p0), word_t'(1));

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_ram_fifo_ctrl_60x84.md
Name: nv_ram_fifo_ctrl_60x84

Overview:
Controller that runs a 60x84 two-port synchronous RAM as a FIFO. The RAM has a registered read address, an output register gated by an output enable, and a bypass mux in front of that register. The block converts a valid/ready push interface and a valid/ready pop interface into the RAM's ra/re/ore/wa/we/di/byp_sel/dbyp strobes. It tracks the two-stage read pipeline and protects the entry being read against overwrite. It sits between a producer and consumer in the core clock domain, next to the RAM instance.

Parameters:
DEPTH, 60, number of RAM entries; pointers wrap DEPTH-1 -> 0
WIDTH, 84, data width
AW, 6, RAM address width
CW, 7, width of fifo_count (holds 0..DEPTH+1)

Ports:
nvdla_core_clk  input  1  core clock; all state on rising edge
nvdla_core_rstn  input  1  asynchronous active-low reset
push_valid  input  1  producer has data
push_ready  output  1  block accepts data this cycle
push_data  input  WIDTH  write data
pop_valid  output  1  pop_data valid
pop_ready  input  1  consumer takes data
pop_data  output  WIDTH  wired from ram_dout
ram_ra  output  AW  RAM read address
ram_re  output  1  RAM read-address register enable
ram_ore  output  1  RAM output-register enable
ram_wa  output  AW  RAM write address
ram_we  output  1  RAM write enable
ram_di  output  WIDTH  RAM write data (= push_data)
ram_byp_sel  output  1  RAM bypass select
ram_dbyp  output  WIDTH  RAM bypass data (= push_data)
ram_dout  input  WIDTH  RAM output register
fifo_count  output  CW  entries held: ram_used + out_vld, range 0..61
idle  output  1  fifo_count==0 and no read in flight

Behaviour:
- State registers:
  - wr_ptr, rd_ptr (AW bits, wrap 59->0)
  - ram_used (0..60): written and not yet captured by ore
  - rd_avail (0..60): written and not yet issued via re
  - s1_vld: address held in the RAM's ra_d
  - out_vld: RAM output register holds data not yet popped
- Reset values: all state 0. Resulting outputs: push_ready=1; pop_valid=0; ram_we=ram_re=ram_ore=ram_byp_sel=0; fifo_count=0; idle=1.
- pop_data is undefined while pop_valid=0.
- Definitions:
  - pop_fire = pop_valid & pop_ready
  - out_free = !out_vld | pop_ready
  - push_fire = push_valid & push_ready
- push_ready = (ram_used < DEPTH). Combinational, with no dependency on pop_ready.
- Bypass (feature on): byp = push_fire & rd_avail==0 & !s1_vld & out_free.
  - ram_ore=1, ram_byp_sel=1, ram_we=0.
  - No pointer or count change; out_vld set next cycle.
- RAM write: ram_we = push_fire & !byp, ram_wa = wr_ptr. On write: wr_ptr++, ram_used++, rd_avail++.
- Stage advance: adv = s1_vld & out_free.
  - ram_ore=1, ram_byp_sel=0.
  - ram_used-- and out_vld set next cycle. The captured entry is released only at this point; until then the write pointer cannot reach it.
- Read issue: ram_re = rd_avail>0 & (!s1_vld | adv), ram_ra = rd_ptr. On issue: rd_ptr++, rd_avail--, s1_vld=1.
- s1_vld next = ram_re | (s1_vld & !adv).
- out_vld next = ram_ore | (out_vld & !pop_fire).
- byp and adv are mutually exclusive, since byp requires !s1_vld.
- Latency from push_fire edge to pop_valid:
  - 3 cycles via RAM: we at E0, re at E1, ore at E2.
  - 1 cycle via bypass.
- A write at E0 can be read by re no earlier than E1, so there is never a same-cycle read/write of one address.
- Simultaneous events: push and pop in one cycle both proceed, and ram_used/rd_avail inc and dec net out.
- When full (ram_used=60, out_vld=1): push_ready=0 until an advance frees a slot. The first push after that advance is accepted the following cycle.
- When pop_ready=0 with out_vld=1: ram_ore=0. RAM output and ra_d both hold, so there is no data loss and no duplication.
- Reset asserted mid-operation: all state clears asynchronously and FIFO contents are discarded. RAM contents need no clearing.
- ram_di and ram_dbyp always equal push_data.

Optional Feature:
NV_RAM_FIFO_BYPASS_EN.
- Defined: bypass path as above; 1-cycle latency when the FIFO is empty; capacity 61 (60 RAM + output register).
- Undefined: byp is tied to 0 and ram_byp_sel=0 constantly; every entry goes through the RAM with 3-cycle latency. Capacity is still 61, because the output register holds one popped-from-RAM entry.

Test Plan:
- Reset, then one push of 84'hA5 with pop_ready=1:
  - bypass on: pop_valid the cycle after push, pop_data=84'hA5, fifo_count returns to 0.
  - bypass off: pop_valid 3 cycles after push.
- pop_ready=0, push 0..70 continuously -> 61 accepted (values 0..60); push_ready=0 from then on; fifo_count=61. Then pop_ready=1 -> values 0..60 popped in order, no gaps.
- Stream 200 incrementing words with push_valid and pop_ready both random (~50%) -> output sequence identical to input; pointers wrap 59->0 at least 3 times; fifo_count never exceeds 61.
- Full FIFO, pop one word -> push_ready rises exactly 1 cycle after the advance that frees the slot; a push in that cycle is written to the freed address.
- 20 words in flight, nvdla_core_rstn pulsed low mid-cycle -> pop_valid=0, fifo_count=0 and push_ready=1 immediately. Next push of 84'h1 pops as 84'h1.
- Simultaneous push and pop at steady count 30 for 50 cycles -> fifo_count stays 30; ram_we and ram_re are each high every cycle.
